// File: rtl/physics_pkg.sv
// Shared types and saturation helpers for the node integration datapath.
package physics_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } integrator_state_t;

    // Clamp a wide signed value into the range of a w-bit signed number.
    function automatic logic signed [31:0] sat_val(input logic signed [31:0] x, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

    function automatic logic sat_hit(input logic signed [31:0] x, input int w);
        return (sat_val(x, w) != x);
    endfunction

endpackage

// File: rtl/node_integrate_unit.sv
// One semi-implicit Euler step for a single node: gravity on y, velocity first,
// then position from the new velocity, both saturated.
module node_integrate_unit
    import physics_pkg::*;
#(
    parameter int POSITION_SIZE = 8,
    parameter int VELOCITY_SIZE = 8,
    parameter int FORCE_SIZE    = 8,
    parameter int ACCEL_SHIFT   = 2,
    parameter int VEL_SHIFT     = 1,
    parameter int GRAVITY_Y     = -4
) (
    input  logic [POSITION_SIZE-1:0] px_i,
    input  logic [POSITION_SIZE-1:0] py_i,
    input  logic [VELOCITY_SIZE-1:0] vx_i,
    input  logic [VELOCITY_SIZE-1:0] vy_i,
    input  logic [FORCE_SIZE-1:0]    fx_i,
    input  logic [FORCE_SIZE-1:0]    fy_i,
    output logic [POSITION_SIZE-1:0] px_o,
    output logic [POSITION_SIZE-1:0] py_o,
    output logic [VELOCITY_SIZE-1:0] vx_o,
    output logic [VELOCITY_SIZE-1:0] vy_o,
    output logic                     sat_o
);

    logic signed [31:0] ax, ay;
    logic signed [31:0] vx_s, vy_s, vx_c, vy_c;
    logic signed [31:0] px_s, py_s, px_c, py_c;

    // Everything is widened to 32 bits so no intermediate can wrap.
    always_comb begin
        ax   = 32'($signed(fx_i));
        ay   = 32'($signed(fy_i)) + GRAVITY_Y;
        vx_s = 32'($signed(vx_i)) + (ax >>> ACCEL_SHIFT);
        vy_s = 32'($signed(vy_i)) + (ay >>> ACCEL_SHIFT);
        vx_c = sat_val(vx_s, VELOCITY_SIZE);
        vy_c = sat_val(vy_s, VELOCITY_SIZE);
        px_s = 32'($signed(px_i)) + (vx_c >>> VEL_SHIFT);
        py_s = 32'($signed(py_i)) + (vy_c >>> VEL_SHIFT);
        px_c = sat_val(px_s, POSITION_SIZE);
        py_c = sat_val(py_s, POSITION_SIZE);
        vx_o = vx_c[VELOCITY_SIZE-1:0];
        vy_o = vy_c[VELOCITY_SIZE-1:0];
        px_o = px_c[POSITION_SIZE-1:0];
        py_o = py_c[POSITION_SIZE-1:0];
        sat_o = sat_hit(vx_s, VELOCITY_SIZE) | sat_hit(vy_s, VELOCITY_SIZE) |
                sat_hit(px_s, POSITION_SIZE) | sat_hit(py_s, POSITION_SIZE);
    end

endmodule

// File: rtl/node_integrator.sv
// Owns the car-body node state and integrates it one node per force beat,
// pulsing step_done once every node of the step has been updated.
module node_integrator
    import physics_pkg::*;
#(
    parameter int NUM_NODES     = 10,
    parameter int POSITION_SIZE = 8,
    parameter int VELOCITY_SIZE = 8,
    parameter int FORCE_SIZE    = 8,
    parameter int ACCEL_SHIFT   = 2,
    parameter int VEL_SHIFT     = 1,
    parameter int GRAVITY_Y     = -4
) (
    input  logic                                            clk_in,
    input  logic                                            rst_in,
    input  logic                                            load_valid_in,
    input  logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]    init_nodes,
    input  logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]    init_velocities,
    input  logic                                            start_in,
    input  logic [FORCE_SIZE-1:0]                           force_x_in,
    input  logic [FORCE_SIZE-1:0]                           force_y_in,
    input  logic                                            force_valid_in,
    output logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]    nodes,
    output logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]    velocities,
    output logic                                            busy,
    output logic                                            step_done,
    output logic                                            sat_flag
);

    localparam int IW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_NODES - 1);

    integrator_state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] pos_q, pos_d;
    logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0] vel_q, vel_d;
    logic sat_q, sat_d;

    logic [POSITION_SIZE-1:0] u_px, u_py;
    logic [VELOCITY_SIZE-1:0] u_vx, u_vy;
    logic                     u_sat;

    node_integrate_unit #(
        .POSITION_SIZE(POSITION_SIZE),
        .VELOCITY_SIZE(VELOCITY_SIZE),
        .FORCE_SIZE   (FORCE_SIZE),
        .ACCEL_SHIFT  (ACCEL_SHIFT),
        .VEL_SHIFT    (VEL_SHIFT),
        .GRAVITY_Y    (GRAVITY_Y)
    ) u_unit (
        .px_i (pos_q[0][idx_q]),
        .py_i (pos_q[1][idx_q]),
        .vx_i (vel_q[0][idx_q]),
        .vy_i (vel_q[1][idx_q]),
        .fx_i (force_x_in),
        .fy_i (force_y_in),
        .px_o (u_px),
        .py_o (u_py),
        .vx_o (u_vx),
        .vy_o (u_vy),
        .sat_o(u_sat)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        vel_d   = vel_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE: begin
                // Load wins over a same-cycle start; that start is dropped.
                if (load_valid_in) begin
                    pos_d = init_nodes;
                    vel_d = init_velocities;
                    sat_d = 1'b0;
                end else if (start_in) begin
                    idx_d   = '0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (force_valid_in) begin
                    pos_d[0][idx_q] = u_px;
                    pos_d[1][idx_q] = u_py;
                    vel_d[0][idx_q] = u_vx;
                    vel_d[1][idx_q] = u_vy;
                    sat_d           = sat_q | u_sat;
                    if (idx_q == LAST) begin
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pos_q   <= '0;
            vel_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            vel_q   <= vel_d;
            sat_q   <= sat_d;
        end
    end

    assign nodes      = pos_q;
    assign velocities = vel_q;
    assign busy       = (state_q == COLLECT);
    assign step_done  = (state_q == DONE);
    assign sat_flag   = sat_q;

endmodule

// File: tb/tb_node_integrator.sv
// Randomized scoreboard bench for node_integrator against a behavioural
// per-cycle model of the integration step (4 nodes, 8-bit widths).
module tb_node_integrator;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_in = 1'b0, load_valid_in = 1'b0, start_in = 1'b0, force_valid_in = 1'b0;
    logic [1:0][N-1:0][7:0] init_nodes = '0, init_velocities = '0;
    logic [7:0] force_x_in = '0, force_y_in = '0;
    logic [1:0][N-1:0][7:0] nodes, velocities;
    logic busy, step_done, sat_flag;

    always #5 clk = ~clk;

    node_integrator #(
        .NUM_NODES(N), .POSITION_SIZE(8), .VELOCITY_SIZE(8), .FORCE_SIZE(8),
        .ACCEL_SHIFT(2), .VEL_SHIFT(1), .GRAVITY_Y(-4)
    ) dut (
        .clk_in(clk), .rst_in(rst_in), .load_valid_in(load_valid_in),
        .init_nodes(init_nodes), .init_velocities(init_velocities),
        .start_in(start_in), .force_x_in(force_x_in), .force_y_in(force_y_in),
        .force_valid_in(force_valid_in), .nodes(nodes), .velocities(velocities),
        .busy(busy), .step_done(step_done), .sat_flag(sat_flag)
    );

    typedef struct {
        logic [1:0][N-1:0][7:0] n;
        logic [1:0][N-1:0][7:0] v;
        logic busy, done, sat;
    } exp_t;
    exp_t sbq[$];

    int n_chk = 0, n_fail = 0;

    // Reference model: positions/velocities as plain ints, plus step progress.
    int m_pos[2][N], m_vel[2][N];
    bit m_sat = 0, m_collecting = 0, m_done = 0;
    int m_next = 0;

    function automatic int clamp8(input int x);
        return (x > 127) ? 127 : (x < -128) ? -128 : x;
    endfunction

    task automatic model_node(input int k, input int fx, input int fy);
        int a[2];
        int vn, pn;
        a[0] = fx;
        a[1] = fy - 4;
        for (int ax = 0; ax < 2; ax++) begin
            vn = m_vel[ax][k] + (a[ax] >>> 2);
            if (clamp8(vn) != vn) m_sat = 1;
            vn = clamp8(vn);
            pn = m_pos[ax][k] + (vn >>> 1);
            if (clamp8(pn) != pn) m_sat = 1;
            m_vel[ax][k] = vn;
            m_pos[ax][k] = clamp8(pn);
        end
    endtask

    task automatic drive(input bit rst, input bit ld, input bit st, input bit fv,
                         input int fx, input int fy);
        exp_t e;
        @(negedge clk);
        rst_in = rst; load_valid_in = ld; start_in = st; force_valid_in = fv;
        force_x_in = 8'(fx); force_y_in = 8'(fy);
        if (rst) begin
            foreach (m_pos[a, i]) begin m_pos[a][i] = 0; m_vel[a][i] = 0; end
            m_sat = 0; m_collecting = 0; m_done = 0; m_next = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_collecting) begin
            if (fv) begin
                model_node(m_next, int'($signed(force_x_in)), int'($signed(force_y_in)));
                m_next++;
                if (m_next == N) begin m_collecting = 0; m_done = 1; end
            end
        end else if (ld) begin
            foreach (m_pos[a, i]) begin
                m_pos[a][i] = int'($signed(init_nodes[a][i]));
                m_vel[a][i] = int'($signed(init_velocities[a][i]));
            end
            m_sat = 0;
        end else if (st) begin
            m_collecting = 1; m_next = 0;
        end
        foreach (m_pos[a, i]) begin
            e.n[a][i] = 8'(m_pos[a][i]);
            e.v[a][i] = 8'(m_vel[a][i]);
        end
        e.busy = m_collecting; e.done = m_done; e.sat = m_sat;
        sbq.push_back(e);
    endtask

    task automatic idle(input int c);
        repeat (c) drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic beat(input int fx, input int fy);
        drive(0, 0, 0, 1, fx, fy);
    endtask

    task automatic settle();
        @(posedge clk); #2;
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Monitor: every edge has exactly one expected snapshot queued by the driver.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            n_chk += 5;
            if (nodes !== e.n) begin n_fail++; $display("FAIL sb_nodes: got %h expected %h", nodes, e.n); end
            if (velocities !== e.v) begin n_fail++; $display("FAIL sb_vel: got %h expected %h", velocities, e.v); end
            if (busy !== e.busy) begin n_fail++; $display("FAIL sb_busy: got %b expected %b", busy, e.busy); end
            if (step_done !== e.done) begin n_fail++; $display("FAIL sb_done: got %b expected %b", step_done, e.done); end
            if (sat_flag !== e.sat) begin n_fail++; $display("FAIL sb_sat: got %b expected %b", sat_flag, e.sat); end
        end
    end

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        idle(1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_pos", int'(nodes == '0), 1);

        // 1: basic step
        init_nodes = '0; init_velocities = '0;
        init_nodes[0][0] = 8'd10; init_nodes[1][0] = 8'd20;
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        beat(8, 0); settle();
        chk("t1_vx", int'($signed(velocities[0][0])), 2);
        chk("t1_vy", int'($signed(velocities[1][0])), -1);
        chk("t1_px", int'($signed(nodes[0][0])), 11);
        chk("t1_py", int'($signed(nodes[1][0])), 19);
        beat(0, 0); beat(0, 0); beat(0, 0); settle();
        chk("t1_done", int'(step_done), 1);
        idle(2);

        // 2: saturation on node 1
        init_nodes = '0; init_velocities = '0;
        init_nodes[0][1] = 8'd127; init_velocities[0][1] = 8'd126;
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        beat(0, 0); beat(40, 0); settle();
        chk("t2_vx", int'($signed(velocities[0][1])), 127);
        chk("t2_px", int'($signed(nodes[0][1])), 127);
        chk("t2_sat", int'(sat_flag), 1);
        beat(0, 0); beat(0, 0); idle(3);
        chk("t2_sat_sticky", int'(sat_flag), 1);

        // 3: negative rounding on node 2
        init_nodes = '0; init_velocities = '0;
        init_nodes[0][2] = 8'd5;
        drive(0, 1, 0, 0, 0, 0);
        chk("t3_sat_clear", int'(sat_flag), 1);
        settle();
        chk("t3_sat_cleared", int'(sat_flag), 0);
        drive(0, 0, 1, 0, 0, 0);
        beat(0, 0); beat(0, 0); beat(-1, 4); settle();
        chk("t3_vx", int'($signed(velocities[0][2])), -1);
        chk("t3_vy", int'($signed(velocities[1][2])), 0);
        chk("t3_px", int'($signed(nodes[0][2])), 4);
        beat(0, 0); idle(2);

        // 4: gapped stream, 5: ignored inputs
        drive(0, 0, 1, 0, 0, 0);
        for (int b = 0; b < N; b++) begin
            repeat (b) drive(0, $urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 0);
            beat(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
        end
        idle(2);
        drive(0, 0, 0, 1, 50, 50); drive(0, 0, 0, 1, -50, 9);
        init_nodes[0][3] = 8'd33;
        drive(0, 1, 1, 0, 0, 0); settle();
        chk("t5_busy", int'(busy), 0);
        chk("t5_load", int'($signed(nodes[0][3])), 33);

        // 6: reset mid-step, then a normal step
        drive(0, 0, 1, 0, 0, 0);
        beat(12, -8); beat(-20, 30);
        drive(1, 0, 0, 0, 0, 0); settle();
        chk("t6_zero", int'(nodes == '0 && velocities == '0), 1);
        chk("t6_nodone", int'(step_done), 0);
        idle(2);
        drive(0, 1, 0, 0, 0, 0); drive(0, 0, 1, 0, 0, 0);
        for (int b = 0; b < N; b++) beat(b * 7 - 10, 3 - b);
        idle(2);

        // Random steps with random loads, gaps, junk inputs and occasional reset.
        for (int s = 0; s < 30; s++) begin
            if ($urandom_range(0, 2) == 0) begin
                foreach (init_nodes[a, i]) begin
                    init_nodes[a][i] = 8'($urandom);
                    init_velocities[a][i] = 8'($urandom);
                end
                drive(0, 1, $urandom_range(0, 1), 0, 0, 0);
            end
            drive(0, 0, 0, $urandom_range(0, 1), 5, 5);
            drive(0, 0, 1, 0, 0, 0);
            for (int b = 0; b < N; b++) begin
                repeat ($urandom_range(0, 2)) drive(0, $urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 0);
                if (s % 9 == 8 && b == 2) drive(1, 0, 0, 0, 0, 0);
                beat(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
            end
            drive(0, 0, 0, 1, 1, 1);
            idle($urandom_range(0, 2));
        end

        idle(1);
        @(posedge clk); #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
